// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch / data) in front of one single-port,
// variable-latency memory. Round-robin on collision, 1-cycle completion pulses, watchdog.
module mem_port_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_if_req,
  input  logic [WORD_SIZE-1:0] i_if_addr,
  output logic [WORD_SIZE-1:0] o_if_rdata,
  output logic                 o_if_valid,
  input  logic                 i_dm_req,
  input  logic                 i_dm_wen,
  input  logic [WORD_SIZE-1:0] i_dm_addr,
  input  logic [WORD_SIZE-1:0] i_dm_wd,
  output logic [WORD_SIZE-1:0] o_dm_rdata,
  output logic                 o_dm_valid,
  output logic                 o_mem_req,
  output logic                 o_mem_wen,
  output logic [WORD_SIZE-1:0] o_mem_addr,
  output logic [WORD_SIZE-1:0] o_mem_wd,
  input  logic                 i_mem_ack,
  input  logic [WORD_SIZE-1:0] i_mem_rdata,
  output logic                 o_stall,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY_DM, BUSY_IF} state_t;

  typedef struct packed {
    logic                 wen;
    logic [WORD_SIZE-1:0] addr;
    logic [WORD_SIZE-1:0] wd;
  } mem_cmd_t;

  localparam bit WD_EN = (TIMEOUT > 0);
  localparam int CW    = WD_EN ? $clog2(TIMEOUT + 1) : 1;

  state_t        state;
  mem_cmd_t      cmd;
  logic          last_dm;
  logic [CW-1:0] wait_cnt;

  logic dm_elig, if_elig, grant_dm, grant_if, wd_hit;

  // A requester whose valid is up this cycle has just been served and must not re-issue.
  assign dm_elig  = i_dm_req & ~o_dm_valid;
  assign if_elig  = i_if_req & ~o_if_valid;
  assign grant_dm = dm_elig & (~if_elig | ~last_dm);
  assign grant_if = if_elig & ~grant_dm;
  assign wd_hit   = WD_EN && (wait_cnt == CW'(TIMEOUT - 1));

  assign o_mem_wen  = cmd.wen;
  assign o_mem_addr = cmd.addr;
  assign o_mem_wd   = cmd.wd;
  assign o_stall    = (i_dm_req & ~o_dm_valid) | (i_if_req & ~o_if_valid);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      cmd        <= '0;
      last_dm    <= 1'b0;
      wait_cnt   <= '0;
      o_mem_req  <= 1'b0;
      o_if_rdata <= '0;
      o_if_valid <= 1'b0;
      o_dm_rdata <= '0;
      o_dm_valid <= 1'b0;
      o_timeout  <= 1'b0;
    end else begin
      o_if_valid <= 1'b0;
      o_dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (grant_dm) begin
            state     <= BUSY_DM;
            o_mem_req <= 1'b1;
            cmd       <= '{wen: i_dm_wen, addr: i_dm_addr, wd: i_dm_wd};
            last_dm   <= 1'b1;
          end else if (grant_if) begin
            state     <= BUSY_IF;
            o_mem_req <= 1'b1;
            cmd       <= '{wen: 1'b0, addr: i_if_addr, wd: '0};
            last_dm   <= 1'b0;
          end
        end
        BUSY_DM, BUSY_IF: begin
          if (i_mem_ack) begin
            o_mem_req <= 1'b0;
            state     <= IDLE;
            wait_cnt  <= '0;
            if (state == BUSY_DM) begin
              o_dm_valid <= 1'b1;
              if (!cmd.wen) o_dm_rdata <= i_mem_rdata;
            end else begin
              o_if_valid <= 1'b1;
              o_if_rdata <= i_mem_rdata;
            end
          end else if (wd_hit) begin
            // Abort without a valid pulse; the requester stays pending and is re-arbitrated.
            o_mem_req <= 1'b0;
            o_timeout <= 1'b1;
            state     <= IDLE;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, collision, fairness, wait states,
// watchdog and async reset, checked with immediate assertions.
module tb_mem_port_arbiter;

  localparam int WS = 32;
  localparam logic [31:0] K = 32'h5A5A_0000;

  logic          clk = 1'b0;
  logic          rstn;
  logic          if_req, dm_req, dm_wen, mem_ack;
  logic [WS-1:0] if_addr, dm_addr, dm_wd, mem_rdata;
  logic [WS-1:0] if_rdata, dm_rdata, mem_addr, mem_wd;
  logic          if_valid, dm_valid, mem_req, mem_wen, stall, timeout;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.WORD_SIZE(WS), .TIMEOUT(8)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
    .i_dm_req(dm_req), .i_dm_wen(dm_wen), .i_dm_addr(dm_addr), .i_dm_wd(dm_wd),
    .o_dm_rdata(dm_rdata), .o_dm_valid(dm_valid),
    .o_mem_req(mem_req), .o_mem_wen(mem_wen), .o_mem_addr(mem_addr), .o_mem_wd(mem_wd),
    .i_mem_ack(mem_ack), .i_mem_rdata(mem_rdata),
    .o_stall(stall), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rstn = 1'b0; if_req = 0; dm_req = 0; dm_wen = 0; mem_ack = 0;
    if_addr = '0; dm_addr = '0; dm_wd = '0; mem_rdata = '0;
    tick(); tick();
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk1("rst_dm_valid", dm_valid, 1'b0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_stall", stall, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rstn = 1'b1;
    tick();

    // ack while idle must be ignored
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 0;
    chk1("idle_ack_no_valid", if_valid | dm_valid, 1'b0);
    chk1("idle_ack_no_req", mem_req, 1'b0);

    // single zero-wait fetch
    if_req = 1; if_addr = 32'h10;
    #1;
    chk1("fetch_stall_c0", stall, 1'b1);
    tick();
    chk1("fetch_mem_req", mem_req, 1'b1);
    chk("fetch_mem_addr", mem_addr, 32'h10);
    chk1("fetch_mem_wen", mem_wen, 1'b0);
    mem_ack = 1; mem_rdata = 32'h0050_0093;
    tick();
    mem_ack = 0;
    chk1("fetch_valid", if_valid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h0050_0093);
    chk1("fetch_req_drop", mem_req, 1'b0);
    chk1("fetch_stall_c2", stall, 1'b0);
    if_req = 0;
    tick();
    chk1("fetch_pulse_1cyc", if_valid, 1'b0);
    chk1("fetch_no_reissue", mem_req, 1'b0);

    // collision right after reset: DM write first, then IF
    rstn = 0; tick(); rstn = 1; tick();
    if_req = 1; if_addr = 32'h44;
    dm_req = 1; dm_wen = 1; dm_addr = 32'h200; dm_wd = 32'hDEAD_BEEF;
    tick();
    chk1("coll_dm_req", mem_req, 1'b1);
    chk1("coll_dm_wen", mem_wen, 1'b1);
    chk("coll_dm_addr", mem_addr, 32'h200);
    chk("coll_dm_wd", mem_wd, 32'hDEAD_BEEF);
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 0;
    chk1("coll_dm_valid", dm_valid, 1'b1);
    chk("coll_dm_rdata_kept", dm_rdata, 32'h0);
    dm_req = 0; dm_wen = 0;
    tick();
    chk1("coll_if_req", mem_req, 1'b1);
    chk("coll_if_addr", mem_addr, 32'h44);
    chk1("coll_if_wen", mem_wen, 1'b0);
    chk("coll_if_wd", mem_wd, 32'h0);
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 0;
    chk1("coll_if_valid", if_valid, 1'b1);
    chk("coll_if_rdata", if_rdata, 32'hCAFE_F00D);
    if_req = 0;
    tick();

    // fairness: both held, last grant was IF, so DM,IF,DM,IF,DM,IF
    dm_req = 1; dm_wen = 0; dm_addr = 32'h300; dm_wd = '0;
    if_req = 1; if_addr = 32'h80;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      if (mem_req) begin
        chk($sformatf("fair_grant%0d", n), mem_addr, (n % 2 == 0) ? 32'h300 : 32'h80);
        mem_rdata = mem_addr ^ K;
        mem_ack = 1;
        n++;
      end else begin
        mem_ack = 0;
      end
      tick();
    end
    chk("fair_count", 32'(n), 32'd6);
    mem_ack = 0; dm_req = 0; if_req = 0;
    chk1("fair_last_if_valid", if_valid, 1'b1);
    chk("fair_if_rdata", if_rdata, 32'h5A5A_0080);
    chk("fair_dm_rdata", dm_rdata, 32'h5A5A_0300);
    tick();
    chk1("fair_quiet", mem_req, 1'b0);

    // four wait states before ack
    dm_req = 1; dm_wen = 0; dm_addr = 32'h400;
    tick();
    for (int w = 0; w < 4; w++) begin
      chk1($sformatf("wait_req%0d", w), mem_req, 1'b1);
      chk($sformatf("wait_addr%0d", w), mem_addr, 32'h400);
      chk1($sformatf("wait_stall%0d", w), stall, 1'b1);
      chk1($sformatf("wait_novalid%0d", w), dm_valid, 1'b0);
      tick();
    end
    chk1("wait_req_at_ack", mem_req, 1'b1);
    mem_ack = 1; mem_rdata = 32'hA5A5_0001;
    tick();
    mem_ack = 0;
    chk1("wait_valid", dm_valid, 1'b1);
    chk("wait_rdata", dm_rdata, 32'hA5A5_0001);
    chk1("wait_stall_clear", stall, 1'b0);
    dm_req = 0;
    tick();
    chk1("wait_pulse_1cyc", dm_valid, 1'b0);

    // watchdog: 8 unacknowledged busy cycles abort, then the fetch is re-issued
    if_req = 1; if_addr = 32'h500;
    tick();
    for (int w = 0; w < 8; w++) begin
      chk1($sformatf("wd_req%0d", w), mem_req, 1'b1);
      chk1($sformatf("wd_flag_low%0d", w), timeout, 1'b0);
      tick();
    end
    chk1("wd_flag", timeout, 1'b1);
    chk1("wd_abort", mem_req, 1'b0);
    chk1("wd_no_valid", if_valid, 1'b0);
    chk1("wd_stall", stall, 1'b1);
    tick();
    chk1("wd_reissue", mem_req, 1'b1);
    chk("wd_reissue_addr", mem_addr, 32'h500);
    mem_ack = 1; mem_rdata = 32'h0000_0077;
    tick();
    mem_ack = 0;
    chk1("wd_retry_valid", if_valid, 1'b1);
    chk("wd_retry_rdata", if_rdata, 32'h77);
    chk1("wd_sticky", timeout, 1'b1);
    if_req = 0;
    tick();

    // async reset in the middle of a DM transaction
    dm_req = 1; dm_wen = 1; dm_addr = 32'h600; dm_wd = 32'h1;
    tick();
    chk1("arst_pre_req", mem_req, 1'b1);
    #2 rstn = 0;
    #1;
    chk1("arst_req", mem_req, 1'b0);
    chk1("arst_timeout", timeout, 1'b0);
    chk1("arst_valids", if_valid | dm_valid, 1'b0);
    dm_req = 0;
    tick();
    rstn = 1;
    tick();
    chk1("arst_idle", mem_req, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog bench_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

endmodule
